// File: rtl/router_fifo.sv
// router_fifo -- per-destination output buffer of the 1x3 router.
//
// Holds header/payload/parity bytes for one output port. Each stored word
// carries an extra bit marking the header byte, so the read side can count
// down the packet (payload + parity) and fall back to an idle output value
// once the parity byte has gone out.
//
// Build option:
//   ROUTER_FIFO_HIZ_EN  defined   -> idle data_out is all-Z (shared tristate bus)
//                       undefined -> idle data_out is all-0
//   data_out resets to 0 in both builds.
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   soft_reset synchronous flush from the synchroniser time-out
//   write_enb  write request (this port's steering bit)
//   read_enb   read request from destination
//   lfd_state  data_in is a packet header
//   data_in    byte to store
//   data_out   registered read data
//   full       all DEPTH entries occupied (combinational)
//   empty      no entries occupied (combinational)

module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

`ifdef ROUTER_FIFO_HIZ_EN
  localparam logic [WIDTH-1:0] IDLE = {WIDTH{1'bz}};
`else
  localparam logic [WIDTH-1:0] IDLE = '0;
`endif

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [6:0]       pkt_cnt;
  logic             do_wr, do_rd;
  logic [WIDTH:0]   rd_word;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_wr   = write_enb && !full;
  assign do_rd   = read_enb && !empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  // Storage has no reset; contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (resetn && !soft_reset && do_wr)
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= IDLE;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_word[WIDTH-1:0];
        // Header loads length + 1 so parity is counted as part of the packet.
        if (rd_word[WIDTH])
          pkt_cnt <= 7'(rd_word[WIDTH-1:2]) + 7'd1;
        else if (pkt_cnt != '0)
          pkt_cnt <= pkt_cnt - 7'd1;
      end else if (pkt_cnt == '0) begin
        data_out <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed + randomized bench for router_fifo against a queue-based model.
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       full, empty;

  int n_vec = 0;
  int n_err = 0;

`ifdef ROUTER_FIFO_HIZ_EN
  localparam logic [7:0] IDLE = 8'bzzzz_zzzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  router_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {is_header, byte}, bytes remaining in the
  // packet currently being delivered, and the expected output register.
  logic [8:0] q[$];
  int         remain;
  logic [7:0] m_dout;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"}, data_out, m_dout);
    chk({tag, ".full"},  {7'd0, full},  {7'd0, q.size() == 16});
    chk({tag, ".empty"}, {7'd0, empty}, {7'd0, q.size() == 0});
  endtask

  // One clock: drive inputs, advance model by the edge rules, then check.
  task automatic step(input string tag, input logic we, input logic re,
                      input logic lfd, input logic [7:0] din,
                      input logic rst_n = 1'b1, input logic srst = 1'b0);
    logic [8:0] w;
    bit rd_ok, wr_ok;
    resetn = rst_n; soft_reset = srst;
    write_enb = we; read_enb = re; lfd_state = lfd; data_in = din;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); remain = 0; m_dout = 8'h00;
    end else if (srst) begin
      q.delete(); remain = 0; m_dout = IDLE;
    end else begin
      rd_ok = re && q.size() > 0;
      wr_ok = we && q.size() < 16;
      if (rd_ok) begin
        w = q.pop_front();
        m_dout = w[7:0];
        if (w[8])            remain = int'(w[7:2]) + 1;
        else if (remain > 0) remain--;
      end else if (remain == 0) begin
        m_dout = IDLE;
      end
      if (wr_ok) q.push_back({lfd, din});
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] hdr_pkt [5];
    hdr_pkt = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5C};
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    remain = 0; m_dout = 8'h00;

    // Reset
    step("rst0", 0, 0, 0, 8'h00, 1'b0);
    step("rst1", 0, 0, 0, 8'h00, 1'b0);
    chk("rst.data_out_zero", data_out, 8'h00);
    step("idle", 0, 0, 0, 8'h00);

    // Fill, overflow drop, drain
    for (int i = 1; i <= 16; i++) step("fill", 1, 0, 0, 8'(i));
    chk("fill.full_set", {7'd0, full}, 8'h01);
    step("ovf", 1, 0, 0, 8'hFF);
    for (int i = 1; i <= 16; i++) begin
      step("drain", 0, 1, 0, 8'h00);
      chk("drain.order", data_out, 8'(i));
    end
    step("drain_idle", 0, 0, 0, 8'h00);

    // Packet back-to-back
    for (int i = 0; i < 5; i++) step("pkt_wr", 1, 0, i == 0, hdr_pkt[i]);
    for (int i = 0; i < 5; i++) begin
      step("pkt_rd", 0, 1, 0, 8'h00);
      chk("pkt_rd.byte", data_out, hdr_pkt[i]);
    end
    step("pkt_idle", 0, 0, 0, 8'h00);
    chk("pkt_idle.value", data_out, IDLE);

    // Soft reset mid-packet (with write and read requested in that cycle)
    for (int i = 0; i < 5; i++) step("sr_wr", 1, 0, i == 0, hdr_pkt[i]);
    step("sr_rd_hdr", 0, 1, 0, 8'h00);
    step("sr_rd_p0", 0, 1, 0, 8'h00);
    step("sr_pulse", 1, 1, 0, 8'h77, 1'b1, 1'b1);
    chk("sr.idle", data_out, IDLE);
    // New packet (length 2) read with gaps: output must hold mid-packet
    step("np_hdr", 1, 0, 1, 8'h0A);
    step("np_p0", 1, 0, 0, 8'h11);
    step("np_p1", 1, 0, 0, 8'h22);
    step("np_par", 1, 0, 0, 8'h33);
    for (int i = 0; i < 4; i++) begin
      step("np_rd", 0, 1, 0, 8'h00);
      step("np_hold", 0, 0, 0, 8'h00);
    end
    step("np_idle", 0, 0, 0, 8'h00);

    // Simultaneous access at full and at empty
    for (int i = 0; i < 16; i++) step("sf_fill", 1, 0, 0, 8'(8'h40 + i));
    step("sf_rw_full", 1, 1, 0, 8'hEE);
    chk("sf.oldest", data_out, 8'h40);
    for (int i = 0; i < 15; i++) step("sf_drain", 0, 1, 0, 8'h00);
    step("sf_idle", 0, 0, 0, 8'h00);
    step("se_rw_empty", 1, 1, 0, 8'h99);
    chk("se.empty_fell", {7'd0, empty}, 8'h00);
    step("se_rd", 0, 1, 0, 8'h00);
    chk("se.landed", data_out, 8'h99);

    // Randomized interleave across pointer wraps, occupancy kept in 1..15
    for (int i = 0; i < 8; i++) step("wr_pre", 1, 0, 0, 8'($urandom));
    for (int i = 0; i < 48; i++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0 && q.size() >= 14) op = 1;
      if (op == 1 && q.size() <= 2)  op = 0;
      step("wrap", op != 1, op != 0, 0, 8'($urandom));
    end
    while (q.size() > 0) step("wrap_drain", 0, 1, 0, 8'h00);
    step("wrap_idle", 0, 0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
